mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Grants one memory port to icache refills or dcache refill and
//            writeback bursts of BEATS beats. Define MEM_ARB_ROUND_ROBIN_EN
//            for round-robin arbitration; dcache-first priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // icache refill port
    input  logic                     ic_req,
    input  logic [ADDR_W-1:0]        ic_addr,
    output logic                     ic_rvalid,
    output logic                     ic_done,
    // dcache refill / writeback port
    input  logic                     dc_req,
    input  logic                     dc_we,
    input  logic [ADDR_W-1:0]        dc_addr,
    input  logic [DATA_W-1:0]        dc_wdata,
    output logic [$clog2(BEATS)-1:0] dc_beat,
    output logic                     dc_rvalid,
    output logic                     dc_done,
    output logic [DATA_W-1:0]        rdata,
    // memory command channel
    output logic                     m_cmd_valid,
    input  logic                     m_cmd_ready,
    output logic                     m_cmd_we,
    output logic [ADDR_W-1:0]        m_cmd_addr,
    // memory beat channels
    input  logic                     m_rvalid,
    input  logic [DATA_W-1:0]        m_rdata,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    output logic [DATA_W-1:0]        m_wdata
);

    localparam int c_beat_w = $clog2(BEATS);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BEATS - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_cmd   = 3'd1;
    localparam logic [2:0] c_st_rdata = 3'd2;
    localparam logic [2:0] c_st_wdata = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_beat_w-1:0] r_beat;
    logic [c_beat_w-1:0] w_beat_nxt;
    logic                r_owner_dc;  // current owner, doubles as last-granted
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_dropped;   // owner released its request mid-burst
    logic                w_grant;
    logic                w_grant_dc;
    logic                w_owner_req;
    logic                w_live;
    logic                w_beat_last;

    assign w_grant = ic_req | dc_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the requester that was not granted last wins.
    assign w_grant_dc = dc_req & (~ic_req | ~r_owner_dc);
`else
    assign w_grant_dc = dc_req;
`endif

    assign w_owner_req = r_owner_dc ? dc_req : ic_req;
    assign w_live      = w_owner_req & ~r_dropped;
    assign w_beat_last = (r_beat == c_last_beat);

    assign m_cmd_we   = r_we;
    assign m_cmd_addr = r_addr;
    assign m_wdata    = dc_wdata;
    assign rdata      = m_rdata;
    assign dc_beat    = r_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        m_cmd_valid = 1'b0;
        m_wvalid    = 1'b0;
        ic_rvalid   = 1'b0;
        dc_rvalid   = 1'b0;
        ic_done     = 1'b0;
        dc_done     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_grant) begin
                    w_state_nxt = c_st_cmd;
                end
            end
            c_st_cmd: begin
                m_cmd_valid = 1'b1;
                if (m_cmd_ready) begin
                    w_state_nxt = r_we ? c_st_wdata : c_st_rdata;
                    w_beat_nxt  = '0;
                end
            end
            c_st_rdata: begin
                if (m_rvalid) begin
                    ic_rvalid  = ~r_owner_dc & w_live;
                    dc_rvalid  = r_owner_dc & w_live;
                    w_beat_nxt = r_beat + 1'b1;
                    if (w_beat_last) begin
                        w_state_nxt = c_st_done;
                    end
                end
            end
            c_st_wdata: begin
                m_wvalid = 1'b1;
                if (m_wready) begin
                    w_beat_nxt = r_beat + 1'b1;
                    if (w_beat_last) begin
                        w_state_nxt = c_st_done;
                    end
                end
            end
            c_st_done: begin
                ic_done     = ~r_owner_dc & w_live;
                dc_done     = r_owner_dc & w_live;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Grant bookkeeping; icache grants always issue reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_dc <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_dropped  <= 1'b0;
        end else if (r_state == c_st_idle) begin
            if (w_grant) begin
                r_owner_dc <= w_grant_dc;
                r_we       <= w_grant_dc & dc_we;
                r_addr     <= w_grant_dc ? dc_addr : ic_addr;
                r_dropped  <= 1'b0;
            end
        end else if (!w_owner_req) begin
            r_dropped <= 1'b1;
        end
    end

endmodule
`default_nettype wire
